// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Brief   : Shared types, constants and hex decode for the 7-segment scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t                  SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;

  // Segment order is {a,b,c,d,e,f,g}, active-low.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module  : seg7_hex_decode
// Brief   : Combinational nibble to active-low segment pattern.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module  : seg7_scan_ctrl
// Brief   : 8-digit multiplexed 7-segment scanner with frame-aligned updates.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [31:0]           value,
  output logic                  ready,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output seg_t                  seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int               DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           disp_val_q, disp_val_d;
  logic [31:0]           pend_val_q, pend_val_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;

  logic                  w_tick;
  logic                  w_frame_end;
  logic [3:0]            w_nibble;
  logic [31:0]           w_upper;
  logic                  w_visible;
  seg_t                  w_dec_seg;

  seg7_hex_decode u_dec (
    .nibble (w_nibble),
    .seg    (w_dec_seg)
  );

  always_comb begin
    w_tick      = (div_cnt_q == DIV_LAST);
    w_frame_end = w_tick && (idx_q == 3'd7);
    div_cnt_d   = w_tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d       = w_tick ? idx_q + 3'd1 : idx_q;

    // A digit is a leading zero when it and every higher nibble are zero.
    w_nibble    = disp_val_q[{idx_q, 2'b00} +: 4];
    w_upper     = disp_val_q >> {idx_q, 2'b00};
    w_visible   = digit_en[idx_q] &&
                  !(blank_lz && (idx_q != 3'd0) && (w_upper == 32'd0));

    an_d        = w_visible ? ~(8'b1 << idx_q) : AN_OFF;
    seg_d       = w_visible ? w_dec_seg : SEG_OFF;

    disp_val_d  = disp_val_q;
    pend_val_d  = pend_val_q;
    pending_d   = pending_q;
    if (w_frame_end && pending_q) begin
      disp_val_d = pend_val_q;
      pending_d  = 1'b0;
    end else if (load && !pending_q) begin
      pend_val_d = value;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= 3'd0;
      disp_val_q <= 32'd0;
      pend_val_q <= 32'd0;
      pending_q  <= 1'b0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign ready = ~pending_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module  : tb_seg7_scan_ctrl
// Brief   : Self-checking bench for seg7_scan_ctrl with a cycle-count model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = 32'd0;
  logic        blank_lz = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        ready;
  logic [6:0]  seg;
  logic [7:0]  an;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .ready    (ready),
    .blank_lz (blank_lz),
    .digit_en (digit_en),
    .seg      (seg),
    .an       (an)
  );

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference: slot position derives purely from cycles since reset.
  int          cyc = 0;
  logic [31:0] m_disp = 0, m_pend = 0;
  bit          m_pending = 0;
  logic [7:0]  exp_an = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;
  bit          exp_ready = 1;
  bit          started = 0;

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; m_disp = 0; m_pend = 0; m_pending = 0;
      exp_an = 8'hFF; exp_seg = 7'h7F;
      started = 1;
    end else begin
      int          idx;
      logic [31:0] hi;
      bit          vis;
      idx = (cyc / RD) % 8;
      hi  = m_disp >> (4 * idx);
      vis = digit_en[idx] && !(blank_lz && idx != 0 && hi == 0);
      exp_an  = vis ? ~(8'd1 << idx) : 8'hFF;
      exp_seg = vis ? hex_tab[hi[3:0]] : 7'h7F;
      if ((cyc % (8 * RD)) == (8 * RD - 1) && m_pending) begin
        m_disp = m_pend; m_pending = 0;
      end else if (load && !m_pending) begin
        m_pend = value; m_pending = 1;
      end
      cyc++;
    end
    exp_ready = !m_pending;
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg || ready !== exp_ready) begin
        errors++;
        $display("FAIL model t=%0t an=%h seg=%b ready=%b required an=%h seg=%b ready=%b",
                 $time, an, seg, ready, exp_an, exp_seg, exp_ready);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic wait_slot_pos(input int pos);
    int k = 0;
    while ((cyc % (8 * RD)) != pos && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("slot_sync_timeout", {31'd0, (cyc % (8 * RD)) == pos}, 32'd1);
  endtask

  // Checks the first cycle of each slot of the frame that starts at the next edge.
  task automatic check_frame(input string name, input logic [7:0] ans [8],
                             input logic [6:0] segs [8]);
    @(negedge clk);
    for (int d = 0; d < 8; d++) begin
      check({name, "_an"}, {24'd0, an}, {24'd0, ans[d]});
      check({name, "_seg"}, {25'd0, seg}, {25'd0, segs[d]});
      repeat (RD) @(negedge clk);
    end
  endtask

  logic [7:0] lit_an_full [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] lit_seg_cnt [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
  logic [7:0] lit_an_lz [8]   = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [6:0] lit_seg_lz [8]  = '{7'b0100100, 7'b0000001, 7'b0001000, 7'h7F,
                                  7'h7F, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    bit ok;

    repeat (3) @(negedge clk);
    check("reset_an", {24'd0, an}, 32'h0000_00FF);
    check("reset_seg", {25'd0, seg}, 32'h0000_007F);
    check("reset_ready", {31'd0, ready}, 32'd1);
    rst = 1'b0;

    value = 32'h7654_3210; load = 1'b1;
    @(negedge clk);
    check("ready_after_load", {31'd0, ready}, 32'd0);
    value = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    load = 1'b0;
    wait_ready();
    check_frame("count", lit_an_full, lit_seg_cnt);

    blank_lz = 1'b1; value = 32'h0000_0A05; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_ready();
    check_frame("lz", lit_an_lz, lit_seg_lz);

    digit_en = 8'h0F;
    ok = 1;
    repeat (16 * RD) begin
      @(negedge clk);
      if (an[7:4] != 4'hF) ok = 0;
    end
    check("digit_en_mask", {31'd0, ok}, 32'd1);
    digit_en = 8'hFF;
    blank_lz = 1'b0;

    wait_slot_pos(0);
    value = 32'h1234_5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_slot_pos(5 * RD);
    check("pending_before_rst", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", {24'd0, an}, 32'h0000_00FF);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    ok = 1;
    repeat (16 * RD) begin
      @(negedge clk);
      if (seg != 7'b0000001) ok = 0;
    end
    check("pending_discarded", {31'd0, ok}, 32'd1);

    repeat (1500) begin
      @(negedge clk);
      load  = ($urandom_range(0, 3) == 0);
      value = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
